// File: rtl/ysyx_23060208_pkg.sv
// Shared constants for the ysyx_23060208 SoC: AXI response/burst codes, CLINT window, FSM encoding.
// The CLINT's optional read-delay stall (CLINT_RDELAY_EN) uses the LFSR seed held here.
package ysyx_23060208_pkg;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;

  // Also used by the interconnect address decode.
  localparam logic [31:0] ClintBase = 32'h0200_0000;
  localparam logic [31:0] ClintMask = 32'hFFFF_0000;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StResp = 2'd1;
  localparam logic [1:0] StWait = 2'd2;

  localparam logic [15:0] ClintLfsrSeed = 16'hACE1;

  // Decode miss beats every other error; only beats of up to 8 bytes, FIXED/INCR, are served.
  function automatic logic [1:0] clint_resp(input logic hit, input logic [2:0] size,
                                            input logic [1:0] burst);
    if (!hit) begin
      return RespDecErr;
    end else if ((size > 3'd3) || (burst == BurstWrap)) begin
      return RespSlvErr;
    end else begin
      return RespOkay;
    end
  endfunction

endpackage

// File: rtl/ysyx_23060208_clint_if.sv
// AXI4 read-only (AR + R) channel bundle between the interconnect and the CLINT.
interface ysyx_23060208_clint_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    arready;
  logic                    arvalid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [3:0]              arid;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    rready;
  logic                    rvalid;
  logic [1:0]              rresp;
  logic [2*DATA_WIDTH-1:0] rdata;
  logic                    rlast;
  logic [3:0]              rid;

  modport master (
    input  arready, rvalid, rresp, rdata, rlast, rid,
    output arvalid, araddr, arid, arlen, arsize, arburst, rready
  );

  modport slave (
    output arready, rvalid, rresp, rdata, rlast, rid,
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready
  );
endinterface

// File: rtl/ysyx_23060208_clint_mtime.sv
// Free-running 64-bit mtime counter advanced once every TICK_DIV clock cycles.
module ysyx_23060208_clint_mtime #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clock,
  input  logic        reset,
  output logic [63:0] o_mtime
);
  localparam int unsigned PsW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PsW-1:0] PsMax = PsW'(TICK_DIV - 1);

  logic [PsW-1:0] r_ps;
  logic [63:0]    r_mtime;
  logic           w_tick;

  assign w_tick = (r_ps == PsMax);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_ps    <= '0;
      r_mtime <= '0;
    end else begin
      r_ps <= w_tick ? '0 : r_ps + PsW'(1);
      if (w_tick) begin
        r_mtime <= r_mtime + 64'd1;
      end
    end
  end

  assign o_mtime = r_mtime;

endmodule

// File: rtl/ysyx_23060208_clint.sv
// CLINT: AXI4 read-only slave returning an mtime snapshot on every beat of a burst.
// Define CLINT_RDELAY_EN to insert 0-7 LFSR-driven stall cycles before each beat.
module ysyx_23060208_clint
  import ysyx_23060208_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TICK_DIV   = 1,
  parameter logic [31:0] BASE_ADDR  = ClintBase,
  parameter logic [31:0] ADDR_MASK  = ClintMask
) (
  input  logic                         clock,
  input  logic                         reset,
  ysyx_23060208_clint_if.slave         bus,
  output logic [63:0]                  mtime_o
);
  logic [1:0]              r_state;
  logic                    r_arready;
  logic                    r_rvalid;
  logic                    r_rlast;
  logic [1:0]              r_rresp;
  logic [3:0]              r_rid;
  logic [7:0]              r_len;
  logic [7:0]              r_beat;
  logic [2*DATA_WIDTH-1:0] r_rdata;
  logic [63:0]             w_mtime;
  logic                    w_hit;
  logic [1:0]              w_resp;
  logic                    w_ar_hs;
  logic                    w_r_hs;

  ysyx_23060208_clint_mtime #(
    .TICK_DIV (TICK_DIV)
  ) u_mtime (
    .clock   (clock),
    .reset   (reset),
    .o_mtime (w_mtime)
  );

  assign w_hit   = (bus.araddr & ADDR_WIDTH'(ADDR_MASK)) == ADDR_WIDTH'(BASE_ADDR);
  assign w_resp  = clint_resp(w_hit, bus.arsize, bus.arburst);
  assign w_ar_hs = bus.arvalid && r_arready;
  assign w_r_hs  = r_rvalid && bus.rready;

`ifdef CLINT_RDELAY_EN
  logic [15:0] r_lfsr;
  logic [2:0]  r_wait;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_lfsr <= ClintLfsrSeed;
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= StIdle;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rresp   <= '0;
      r_rid     <= '0;
      r_len     <= '0;
      r_beat    <= '0;
      r_rdata   <= '0;
`ifdef CLINT_RDELAY_EN
      r_wait    <= '0;
`endif
    end else begin
      case (r_state)
        StIdle: begin
          r_arready <= 1'b1;
          if (w_ar_hs) begin
            r_arready <= 1'b0;
            r_rid     <= bus.arid;
            r_len     <= bus.arlen;
            r_beat    <= '0;
            r_rlast   <= (bus.arlen == 8'd0);
            r_rresp   <= w_resp;
            // Snapshot is the pre-increment value; errors return zero data.
            r_rdata   <= (w_resp == RespOkay) ? (2*DATA_WIDTH)'(w_mtime) : '0;
`ifdef CLINT_RDELAY_EN
            if (r_lfsr[2:0] == 3'd0) begin
              r_state  <= StResp;
              r_rvalid <= 1'b1;
            end else begin
              r_state <= StWait;
              r_wait  <= r_lfsr[2:0] - 3'd1;
            end
`else
            r_state  <= StResp;
            r_rvalid <= 1'b1;
`endif
          end
        end
        StResp: begin
          if (w_r_hs) begin
            if (r_rlast) begin
              r_state   <= StIdle;
              r_rvalid  <= 1'b0;
              r_arready <= 1'b1;
            end else begin
              r_beat  <= r_beat + 8'd1;
              r_rlast <= (r_beat + 8'd1 == r_len);
`ifdef CLINT_RDELAY_EN
              if (r_lfsr[2:0] != 3'd0) begin
                r_state  <= StWait;
                r_rvalid <= 1'b0;
                r_wait   <= r_lfsr[2:0] - 3'd1;
              end
`endif
            end
          end
        end
`ifdef CLINT_RDELAY_EN
        StWait: begin
          if (r_wait == 3'd0) begin
            r_state  <= StResp;
            r_rvalid <= 1'b1;
          end else begin
            r_wait <= r_wait - 3'd1;
          end
        end
`endif
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.arready = r_arready;
  assign bus.rvalid  = r_rvalid;
  assign bus.rlast   = r_rlast;
  assign bus.rresp   = r_rresp;
  assign bus.rid     = r_rid;
  assign bus.rdata   = r_rdata;
  assign mtime_o     = w_mtime;

endmodule
